// File: rtl/automatic_door_controller.sv
// Automatic bi-parting sliding door controller.
// Moore FSM driving four motor enables, with a bolt indicator and a sticky
// tamper alarm raised by repeated manual-open attempts on a locked, closed door.
module automatic_door_controller #(
    parameter int unsigned ALARM_TRIES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pa,
    input  logic       pp,
    input  logic       mo,
    input  logic       r,
    input  logic       l,
    input  logic       m,
    input  logic       lk,
    output logic [1:0] yt,
    output logic [1:0] yt1,
    output logic       m2r,
    output logic       m2l,
    output logic       r2m,
    output logic       l2m,
    output logic       bt,
    output logic       alarm
);

    typedef enum logic [1:0] {
        CLOSED  = 2'b00,
        OPENING = 2'b01,
        OPEN    = 2'b10,
        CLOSING = 2'b11
    } door_state_e;

    localparam logic [1:0] TRIES = 2'(ALARM_TRIES);

    door_state_e state_q, state_d;
    logic [1:0]  cnt_q;
    logic        mo_q;
    logic        alarm_q;
    logic        open_drv_q;
    logic        close_drv_q;
    logic        attempt;

    // Next-state selection; earlier branches take priority within each state.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            CLOSED: begin
                if (lk)
                    state_d = CLOSED;
                else if (pa || mo)
                    state_d = OPENING;
            end
            OPENING: begin
                if (r && l)
                    state_d = OPEN;
            end
            OPEN: begin
                if (!(pa || pp))
                    state_d = CLOSING;
            end
            CLOSING: begin
                if (pa || pp || mo)
                    state_d = OPENING;
                else if (m)
                    state_d = CLOSED;
            end
            default: state_d = CLOSED;
        endcase
    end

    // A manual-open attempt is a fresh mo rising edge against a locked, closed door.
    assign attempt = (state_q == CLOSED) && lk && mo && !mo_q;

    // State, attempt counter, alarm and motor drives all update together.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!reset) begin
            state_q     <= CLOSED;
            cnt_q       <= 2'd0;
            mo_q        <= 1'b0;
            alarm_q     <= 1'b0;
            open_drv_q  <= 1'b0;
            close_drv_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mo_q        <= mo;
            // Drives are registered from the next state so they track yt with no extra delay.
            open_drv_q  <= (state_d == OPENING);
            close_drv_q <= (state_d == CLOSING);

            if (attempt && (cnt_q != TRIES)) begin
                cnt_q <= cnt_q + 2'd1;
                if ((cnt_q + 2'd1) == TRIES)
                    alarm_q <= 1'b1;
            end else if (!lk && !alarm_q) begin
                cnt_q <= 2'd0;
            end
        end
    end

    assign yt    = state_q;
    assign yt1   = state_d;
    assign m2r   = open_drv_q;
    assign m2l   = open_drv_q;
    assign r2m   = close_drv_q;
    assign l2m   = close_drv_q;
    // Bolt follows lk combinationally so an unlock releases it the same cycle.
    assign bt    = (state_q == CLOSED) && lk;
    assign alarm = alarm_q;

endmodule

// File: tb/tb_automatic_door_controller.sv
// Self-checking bench for automatic_door_controller: directed scenarios
// followed by randomized sensor traffic, all checked against a behavioural model.
module tb_automatic_door_controller;

    localparam int TRIES = 3;

    logic       clk = 1'b0;
    logic       reset, pa, pp, mo, r, l, m, lk;
    logic [1:0] yt, yt1;
    logic       m2r, m2l, r2m, l2m, bt, alarm;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: door position as 0..3 (closed, opening, open, closing),
    // attempts as a plain integer, previous mo, sticky alarm flag.
    int md_state    = 0;
    int md_attempts = 0;
    bit md_mo_prev  = 0;
    bit md_alarm    = 0;
    bit model_valid = 0;

    automatic_door_controller #(.ALARM_TRIES(TRIES)) dut (
        .clk   (clk),
        .reset (reset),
        .pa    (pa),
        .pp    (pp),
        .mo    (mo),
        .r     (r),
        .l     (l),
        .m     (m),
        .lk    (lk),
        .yt    (yt),
        .yt1   (yt1),
        .m2r   (m2r),
        .m2l   (m2l),
        .r2m   (r2m),
        .l2m   (l2m),
        .bt    (bt),
        .alarm (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Door rules stated directly: where should the door be heading next.
    function automatic int model_next(int st, bit i_pa, bit i_pp, bit i_mo,
                                      bit i_r, bit i_l, bit i_m, bit i_lk);
        bit someone = i_pa || i_pp;
        if (st == 0) return (!i_lk && (i_pa || i_mo)) ? 1 : 0;
        if (st == 1) return (i_r && i_l) ? 2 : 1;
        if (st == 2) return someone ? 2 : 3;
        if (someone || i_mo) return 1;
        return i_m ? 0 : 3;
    endfunction

    // One clock cycle: drive at the falling edge, check combinational outputs,
    // advance the model at the rising edge, then check registered outputs.
    task automatic cycle(input bit i_rst, input bit i_pa, input bit i_pp, input bit i_mo,
                         input bit i_r, input bit i_l, input bit i_m, input bit i_lk);
        int nxt;
        @(negedge clk);
        reset = i_rst; pa = i_pa; pp = i_pp; mo = i_mo;
        r = i_r; l = i_l; m = i_m; lk = i_lk;
        #1;
        nxt = model_next(md_state, i_pa, i_pp, i_mo, i_r, i_l, i_m, i_lk);
        if (model_valid) begin
            check("yt1", yt1, nxt);
            check("bt",  bt, (md_state == 0) && i_lk);
        end
        @(posedge clk);
        if (!i_rst) begin
            md_state = 0; md_attempts = 0; md_mo_prev = 0; md_alarm = 0;
        end else begin
            if (md_state == 0 && i_lk && i_mo && !md_mo_prev && md_attempts < TRIES)
                md_attempts++;
            if (md_attempts >= TRIES) md_alarm = 1;
            if (!i_lk && !md_alarm) md_attempts = 0;
            md_mo_prev = i_mo;
            md_state   = nxt;
        end
        model_valid = 1;
        #1;
        check("yt",    yt, md_state);
        check("m2r",   m2r, md_state == 1);
        check("m2l",   m2l, md_state == 1);
        check("r2m",   r2m, md_state == 3);
        check("l2m",   l2m, md_state == 3);
        check("alarm", alarm, md_alarm);
    endtask

    // Shorthands (reset deasserted) for readable directed sequences.
    task automatic step(input bit i_pa, input bit i_pp, input bit i_mo,
                        input bit i_r, input bit i_l, input bit i_m, input bit i_lk);
        cycle(1'b1, i_pa, i_pp, i_mo, i_r, i_l, i_m, i_lk);
    endtask

    task automatic do_reset();
        cycle(1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit s_pa, s_pp, s_mo, s_r, s_l, s_m, s_lk, s_rst;
        reset = 1'b1; pa = 0; pp = 0; mo = 0; r = 0; l = 0; m = 0; lk = 0;

        // Reset and a full open/close cycle.
        do_reset();
        check("rst_yt", yt, 2'b00);
        check("rst_alarm", alarm, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0);              // pa -> OPENING
        check("open_yt", yt, 2'b01);
        check("open_m2r", m2r, 1'b1);
        step(1, 0, 0, 1, 0, 0, 0);              // one limit alone: stay OPENING
        check("one_limit", yt, 2'b01);
        step(1, 0, 0, 1, 1, 0, 0);              // r&l with pa -> OPEN
        check("opened_yt", yt, 2'b10);
        repeat (3) step(0, 1, 0, 1, 1, 0, 0);   // hold open with pp
        check("hold_yt", yt, 2'b10);
        step(0, 0, 0, 1, 1, 0, 0);              // empty -> CLOSING
        check("closing_r2m", r2m, 1'b1);
        step(0, 1, 0, 0, 0, 1, 0);              // m and pp together -> reversal
        check("reverse_yt", yt, 2'b01);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);              // m -> CLOSED
        check("closed_yt", yt, 2'b00);

        // Lock blocks opening; unlocking releases the bolt and opens.
        step(0, 0, 0, 0, 0, 1, 1);
        check("lock_bt", bt, 1'b1);
        step(1, 0, 0, 0, 0, 1, 1);
        check("lock_stay", yt, 2'b00);
        step(1, 0, 0, 0, 0, 1, 0);
        check("unlock_open", yt, 2'b01);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Tamper alarm on the third pulse.
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 1, 0, 0, 1, 1);
            check("tamper_alarm", alarm, i == 3);
            step(0, 0, 0, 0, 0, 1, 1);
        end
        step(0, 0, 0, 0, 0, 1, 0);              // unlock does not clear alarm
        check("alarm_sticky", alarm, 1'b1);
        do_reset();
        check("alarm_cleared", alarm, 1'b0);
        step(0, 0, 1, 0, 0, 1, 0);              // mo unlocked -> OPENING
        check("mo_open", yt, 2'b01);

        // A held mo counts once: hold + two pulses reaches the limit.
        do_reset();
        repeat (4) step(0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 1, 0, 0, 1, 1);
        check("held_once", alarm, 1'b0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 1, 0, 0, 1, 1);
        check("held_third", alarm, 1'b1);
        do_reset();

        // Randomized traffic.
        s_lk = 0;
        for (int i = 0; i < 800; i++) begin
            s_rst = ($urandom_range(0, 59) != 0);
            s_pa  = ($urandom_range(0, 3) == 0);
            s_pp  = ($urandom_range(0, 4) == 0);
            s_mo  = ($urandom_range(0, 4) == 0);
            s_r   = ($urandom_range(0, 9) < 4);
            s_l   = ($urandom_range(0, 9) < 4);
            s_m   = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 9) == 0) s_lk = ~s_lk;
            cycle(s_rst, s_pa, s_pp, s_mo, s_r, s_l, s_m, s_lk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/automatic_door_controller.md
Name: automatic_door_controller

Overview:
- Moore-style FSM controller for a motorised bi-parting sliding door.
- Inputs: person-approach, person-present and manual-open sensors, three door-position limit switches, and a lock request.
- Outputs: four motor enables, a bolt indicator, and a tamper alarm.
- Sits between the door sensor front-end and the motor/bolt drivers; exports present and next state for monitoring.

Parameters:
- ALARM_TRIES, 3, number of manual-open attempts on a locked, closed door that raises alarm (range 1..3; counter is 2 bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- pa  input  1  person approaching sensor.
- pp  input  1  person present in door frame.
- mo  input  1  manual open request.
- r  input  1  right door at right (fully open) limit.
- l  input  1  left door at left (fully open) limit.
- m  input  1  both doors at middle (closed) limit.
- lk  input  1  lock request.
- yt  output  2  present state, registered.
- yt1  output  2  next state, combinational.
- m2r  output  1  drive right door middle->right (open).
- m2l  output  1  drive left door middle->left (open).
- r2m  output  1  drive right door right->middle (close).
- l2m  output  1  drive left door left->middle (close).
- bt  output  1  door bolted.
- alarm  output  1  tamper alarm.

Behaviour:
- State encoding:
  - CLOSED=2'b00
  - OPENING=2'b01
  - OPEN=2'b10
  - CLOSING=2'b11
- yt updates to yt1 every clk edge when reset=1.
- reset=0 at a clk edge: yt=CLOSED, attempt counter=0, mo_d=0, alarm=0. Reset overrides everything, including mid-opening/closing and an active alarm.
- Next-state logic (yt1), priority in listed order:
  - CLOSED:
    - lk=1 -> CLOSED (pa and mo ignored).
    - else pa|mo -> OPENING.
    - else CLOSED.
  - OPENING:
    - r&l -> OPEN.
    - else OPENING. A single limit alone is not enough.
  - OPEN:
    - pa|pp -> OPEN.
    - else CLOSING.
  - CLOSING:
    - pa|pp|mo -> OPENING. Obstruction/re-approach reversal takes priority over m.
    - else m -> CLOSED.
    - else CLOSING.
  - lk has no effect outside CLOSED.
- Outputs, decoded from yt only (Moore):
  - m2r = m2l = (yt==OPENING).
  - r2m = l2m = (yt==CLOSING).
  - Opening and closing drives are never asserted together.
  - bt = (yt==CLOSED) & lk. Combinational on lk, so unlocking drops bt the same cycle.
- Attempt counter:
  - mo_d is mo registered each cycle.
  - An attempt is a rising edge of mo (mo=1, mo_d=0) sampled while yt==CLOSED and lk=1.
  - Each attempt increments a 2-bit counter, saturating at ALARM_TRIES.
  - When the counter reaches ALARM_TRIES, alarm is set on the same clk edge that registers the final attempt. alarm is a registered output.
  - A held mo counts once only.
- Alarm clearing:
  - alarm is sticky; only reset clears it.
  - If lk=0 and alarm=0, the counter clears to 0.
  - Once alarm=1, unlocking does not clear it.
- Simultaneous events:
  - pa and lk together in CLOSED -> stay CLOSED.
  - r&l and pa in OPENING -> OPEN.
  - m and pp in CLOSING -> OPENING.
- Latency: sensor change to yt change is 1 clk. Motor outputs follow yt with zero added delay.

Test Plan:
- Reset and open cycle:
  - reset=0 one edge -> yt=00, all motors 0, alarm=0.
  - pa=1 -> next edge yt=01, m2r=m2l=1.
  - r=l=1 -> yt=10, motors 0.
  - pa=0 -> yt=11, r2m=l2m=1.
  - m=1 -> yt=00.
- Hold open: in OPEN with pp=1 for 3 cycles -> yt stays 10. pp=0 -> yt=11.
- Reversal: in CLOSING with m=1 and pp=1 on the same edge -> yt=01, m2r=m2l=1.
- Lock:
  - in CLOSED with lk=1 -> bt=1.
  - pa=1 -> yt stays 00, motors 0.
  - lk=0 -> bt=0 immediately, then yt=01 at the next edge.
- Tamper alarm:
  - CLOSED, lk=1, mo pulsed 1-0 three times -> alarm=0 after pulses 1 and 2, alarm=1 at the edge of pulse 3.
  - mo held high for 4 cycles counts as one attempt.
- Alarm clear:
  - with alarm=1, set lk=0 -> alarm stays 1.
  - reset=0 one edge -> alarm=0, yt=00.
  - then mo=1 with lk=0 -> yt=01.
